// File: rtl/prom_frame_snapshot.sv
// prom_frame_snapshot: captures averaged frames of M points from the coherent
// averager, normalises each point by an arithmetic right shift and stores the
// frame in a ping-pong buffer. The processor reads the stable bank and releases
// it with frame_ack while the next frame fills the other bank.
module prom_frame_snapshot #(
    parameter int BUF_TAM = 2048,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [15:0]                 ptos_x_ciclo,
    input  logic [4:0]                  shift_norm,
    input  logic                        data_in_valid,
    input  logic signed [DATA_W-1:0]    data_in,
    input  logic                        rd_en,
    input  logic [$clog2(BUF_TAM)-1:0]  rd_addr,
    output logic signed [DATA_W-1:0]    rd_data,
    output logic                        rd_data_valid,
    output logic                        frame_ready,
    input  logic                        frame_ack,
    output logic [15:0]                 frame_count,
    output logic [15:0]                 frames_dropped
);

    localparam int AW = $clog2(BUF_TAM);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]               state;
    logic [AW:0]              m_eff;
    logic signed [DATA_W-1:0] data_reg;
    logic                     valid_reg;
    logic signed [DATA_W-1:0] norm_data;
    logic                     wr_bank;
    logic                     rd_bank;
    logic [AW-1:0]            wr_idx;
    logic                     do_write;
    logic                     last_point;
    logic                     complete;
    logic                     deliver;

    // Both banks live in one array; the bank bit is the top address bit.
    logic signed [DATA_W-1:0] mem [0:2*BUF_TAM-1];

    // Frame length clamped to the bank size, plus the write/completion decode.
    always_comb begin
        m_eff = (ptos_x_ciclo > 16'(BUF_TAM)) ? (AW+1)'(BUF_TAM) : ptos_x_ciclo[AW:0];
        norm_data  = data_reg >>> shift_norm;
        do_write   = (state == ST_FILL) && enable && valid_reg;
        last_point = ({1'b0, wr_idx} == (m_eff - (AW+1)'(1)));
        complete   = do_write && last_point;
        deliver    = complete && (!frame_ready || frame_ack);
    end

    // Stage 1: register the upstream sample; only samples seen while filling count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            data_reg  <= data_in;
            valid_reg <= data_in_valid && enable && (state == ST_FILL);
        end
    end

    // Control: state, write pointer, bank swap and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            wr_idx         <= '0;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b1;
            frame_ready    <= 1'b0;
            frame_count    <= '0;
            frames_dropped <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wr_idx <= '0;
                    if (enable && (m_eff != '0)) begin
                        state <= ST_FILL;
                    end
                end
                default: begin
                    if (!enable) begin
                        state  <= ST_IDLE;
                        wr_idx <= '0;
                    end else if (do_write) begin
                        if (last_point) begin
                            wr_idx <= '0;
                        end else begin
                            wr_idx <= wr_idx + AW'(1);
                        end
                    end
                end
            endcase

            if (deliver) begin
                wr_bank     <= rd_bank;
                rd_bank     <= wr_bank;
                frame_ready <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else begin
                if (complete && (frames_dropped != 16'hFFFF)) begin
                    frames_dropped <= frames_dropped + 16'd1;
                end
                if (frame_ack && frame_ready) begin
                    frame_ready <= 1'b0;
                end
            end
        end
    end

    // Stage 2: store the normalised point into the bank being filled.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[{wr_bank, wr_idx}] <= norm_data;
        end
    end

    // Read port: one-cycle latency from the read bank, zero beyond the frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= rd_en;
            if (rd_en) begin
                if ({1'b0, rd_addr} < m_eff) begin
                    rd_data <= mem[{rd_bank, rd_addr}];
                end else begin
                    rd_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_prom_frame_snapshot.sv
// Testbench for prom_frame_snapshot: directed sequence with random sample data,
// checked against a frame-level reference model (queues of expected points).
module tb_prom_frame_snapshot;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] ptos_x_ciclo;
    logic [4:0]  shift_norm;
    logic        data_in_valid;
    logic [31:0] data_in;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        frame_ready;
    logic        frame_ack;
    logic [15:0] frame_count;
    logic [15:0] frames_dropped;

    int n_assert;
    int n_fail;

    // Reference model: the delivered frame, the frame being captured, counters.
    logic [31:0] exp_frame[$];
    logic [31:0] cur[$];
    int          exp_ready;
    int          exp_count;
    int          exp_dropped;
    int          m_eff_now;
    bit          capturing;

    prom_frame_snapshot #(.BUF_TAM(2048), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .ptos_x_ciclo   (ptos_x_ciclo),
        .shift_norm     (shift_norm),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_data_valid  (rd_data_valid),
        .frame_ready    (frame_ready),
        .frame_ack      (frame_ack),
        .frame_count    (frame_count),
        .frames_dropped (frames_dropped)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input int p);
        return (p > 2048) ? 2048 : p;
    endfunction

    // Reconfigure with an enable toggle so the next frame starts at point 0.
    task automatic set_config(input int m, input int sh);
        enable = 1'b0;
        tick();
        ptos_x_ciclo = 16'(m);
        shift_norm   = 5'(sh);
        cur.delete();
        m_eff_now = eff_len(m);
        enable = 1'b1;
        tick();
        capturing = (m_eff_now != 0);
    endtask

    // One upstream sample; the model records its normalised value.
    task automatic applyStimulus(input logic [31:0] d);
        logic signed [31:0] sv;
        logic signed [31:0] nv;
        data_in       = d;
        data_in_valid = 1'b1;
        if (capturing) begin
            sv = d;
            nv = sv >>> shift_norm;
            cur.push_back(nv);
        end
        tick();
        data_in_valid = 1'b0;
    endtask

    // Cycle in which the last point is written; optional simultaneous ack.
    task automatic finish_frame(input bit ack, input string tag);
        checkOutput({tag, "_ready_before"}, {31'd0, frame_ready}, 32'(exp_ready));
        frame_ack = ack;
        tick();
        frame_ack = 1'b0;
        if (exp_ready == 0 || ack) begin
            exp_frame = cur;
            exp_ready = 1;
            exp_count = (exp_count + 1) & 16'hFFFF;
        end else if (exp_dropped < 65535) begin
            exp_dropped++;
        end
        cur.delete();
        checkOutput({tag, "_ready"},   {31'd0, frame_ready}, 32'(exp_ready));
        checkOutput({tag, "_count"},   {16'd0, frame_count}, 32'(exp_count));
        checkOutput({tag, "_dropped"}, {16'd0, frames_dropped}, 32'(exp_dropped));
    endtask

    task automatic ack_frame(input string tag);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        exp_ready = 0;
        checkOutput({tag, "_ack_ready"}, {31'd0, frame_ready}, 32'(exp_ready));
    endtask

    task automatic read_check(input int addr, input string tag);
        logic [31:0] exp;
        rd_en   = 1'b1;
        rd_addr = 11'(addr);
        tick();
        rd_en = 1'b0;
        exp = (addr < m_eff_now && addr < exp_frame.size()) ? exp_frame[addr] : 32'd0;
        checkOutput($sformatf("%s_rdv%0d", tag, addr), {31'd0, rd_data_valid}, 32'd1);
        checkOutput($sformatf("%s_rd%0d", tag, addr), rd_data, exp);
    endtask

    task automatic random_frame(input int m);
        for (int i = 0; i < m; i++) begin
            applyStimulus($urandom);
        end
    endtask

    // Directed test sequence.
    initial begin
        n_assert = 0; n_fail = 0;
        exp_ready = 0; exp_count = 0; exp_dropped = 0;
        m_eff_now = 0; capturing = 0;
        reset = 1'b0; enable = 1'b0; ptos_x_ciclo = 16'd0; shift_norm = 5'd0;
        data_in_valid = 1'b0; data_in = 32'd0; rd_en = 1'b0; rd_addr = 11'd0;
        frame_ack = 1'b0;
        repeat (3) tick();
        checkOutput("rst_rd_data", rd_data, 32'd0);
        checkOutput("rst_rd_valid", {31'd0, rd_data_valid}, 32'd0);
        checkOutput("rst_ready", {31'd0, frame_ready}, 32'd0);
        checkOutput("rst_count", {16'd0, frame_count}, 32'd0);
        checkOutput("rst_dropped", {16'd0, frames_dropped}, 32'd0);
        reset = 1'b1;
        tick();

        $display("[TB] single frame M=8 shift=2");
        set_config(8, 2);
        for (int i = 1; i <= 8; i++) applyStimulus(32'(4 * i));
        finish_frame(1'b0, "single");
        for (int a = 0; a < 8; a++) read_check(a, "single");
        read_check(8, "single_oob");
        read_check(2047, "single_oob");

        $display("[TB] signed shift M=4 shift=3");
        ack_frame("signed");
        set_config(4, 3);
        applyStimulus(32'hFFFF_FFF8);
        applyStimulus(32'hFFFF_FFF7);
        applyStimulus(32'h0000_0007);
        applyStimulus(32'h7FFF_FFF8);
        finish_frame(1'b0, "signed");
        for (int a = 0; a < 4; a++) read_check(a, "signed");

        $display("[TB] drop with no ack");
        ack_frame("drop");
        set_config(4, $urandom_range(0, 31));
        random_frame(4); finish_frame(1'b0, "drop_f1");
        random_frame(4); finish_frame(1'b0, "drop_f2");
        random_frame(4); finish_frame(1'b0, "drop_f3");
        for (int a = 0; a < 4; a++) read_check(a, "drop");
        ack_frame("drop");
        random_frame(4); finish_frame(1'b0, "drop_f4");
        for (int a = 0; a < 4; a++) read_check(a, "drop_f4");

        $display("[TB] ack coincident with completion");
        random_frame(4); finish_frame(1'b1, "simul");
        for (int a = 0; a < 4; a++) read_check(a, "simul");

        $display("[TB] enable low mid-frame");
        set_config(8, $urandom_range(0, 31));
        random_frame(5);
        enable = 1'b0;
        capturing = 0;
        cur.delete();
        for (int a = 0; a < 4; a++) read_check(a, "enlow_prior");
        ack_frame("enlow");
        enable = 1'b1;
        tick();
        capturing = 1;
        random_frame(8); finish_frame(1'b0, "enlow");
        for (int a = 0; a < 8; a++) read_check(a, "enlow");

        $display("[TB] ptos_x_ciclo = 0");
        ack_frame("zero");
        set_config(0, 0);
        random_frame(10);
        repeat (3) tick();
        checkOutput("zero_ready", {31'd0, frame_ready}, 32'(exp_ready));
        checkOutput("zero_count", {16'd0, frame_count}, 32'(exp_count));
        read_check(0, "zero");

        $display("[TB] ptos_x_ciclo = 3000 clamps to 2048");
        set_config(3000, $urandom_range(0, 31));
        random_frame(2047);
        checkOutput("big_not_yet", {31'd0, frame_ready}, 32'd0);
        applyStimulus($urandom);
        finish_frame(1'b0, "big");
        read_check(0, "big");
        read_check(1000, "big");
        read_check($urandom_range(0, 2047), "big");
        read_check(2047, "big");

        $display("[TB] reset mid-frame");
        ack_frame("rstmid");
        set_config(4, $urandom_range(0, 31));
        random_frame(3);
        reset = 1'b0;
        tick();
        exp_ready = 0; exp_count = 0; exp_dropped = 0;
        cur.delete();
        checkOutput("rstmid_ready", {31'd0, frame_ready}, 32'd0);
        checkOutput("rstmid_count", {16'd0, frame_count}, 32'd0);
        checkOutput("rstmid_dropped", {16'd0, frames_dropped}, 32'd0);
        checkOutput("rstmid_rd_valid", {31'd0, rd_data_valid}, 32'd0);
        reset = 1'b1;
        tick();
        random_frame(4); finish_frame(1'b0, "rstmid");
        for (int a = 0; a < 4; a++) read_check(a, "rstmid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #2000000;
        n_assert++;
        n_fail++;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/prom_frame_snapshot.md
# prom_frame_snapshot

Downstream stage of the coherent averager. Captures each averaged frame of M points from the averager's streaming output, normalises every point by an arithmetic right shift (divide by N = 2^shift_norm), and stores it in a ping-pong buffer. The processor reads a stable frame through a simple read port and releases it with an acknowledge, while the next frame fills the other bank.

## Interface
Parameters:
- BUF_TAM, 2048: points per bank; the address width is log2(BUF_TAM) = 11.
- DATA_W, 32: sample width, signed.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- enable  in  1  capture enable.
- ptos_x_ciclo  in  16  M, points per frame.
- shift_norm  in  5  normalisation shift, 0..31.
- data_in_valid  in  1  upstream sample valid.
- data_in  in  DATA_W  signed upstream sum, one per valid.
- rd_en  in  1  read strobe.
- rd_addr  in  11  point index to read.
- rd_data  out  DATA_W  signed read data.
- rd_data_valid  out  1  rd_data valid.
- frame_ready  out  1  read bank holds an unread complete frame.
- frame_ack  in  1  single-cycle pulse that releases the read bank.
- frame_count  out  16  frames delivered, wraps at 16 bits.
- frames_dropped  out  16  frames discarded, saturates at 0xFFFF.

## Operation
- Storage: two banks of BUF_TAM × DATA_W. wr_bank and rd_bank always differ. wr_idx is the write pointer.
- Effective M: M_eff = min(ptos_x_ciclo, BUF_TAM). If M_eff = 0, the block stays in IDLE and writes nothing.
- States and transitions:
  - IDLE → FILL when enable=1 and M_eff≠0.
  - In FILL, any state with enable=0 → IDLE.
  - In IDLE: wr_idx=0 and any partial frame is discarded. rd_bank contents, frame_ready and both counters are retained, so reads still work.
- Alignment: the first valid after entering FILL is point 0. This matches the averager, which emits bursts of M points starting at index 0.
- Pipeline:
  - Stage 1 registers data_in and data_in_valid.
  - Stage 2 writes (data_reg >>> shift_norm) to wr_bank[wr_idx].
  - The shift is arithmetic (sign-preserving) and truncates toward −∞. shift_norm is sampled in stage 2.
- wr_idx increments per valid and wraps to 0 after M_eff−1.
- Frame completion, when point M_eff−1 is written:
  - If frame_ready=0 (or frame_ack is seen in the same cycle): swap banks, frame_ready←1, frame_count+1.
  - Otherwise: the frame is dropped, wr_bank is kept and overwritten from 0, and frames_dropped increments (saturating).
- frame_ack:
  - When frame_ready=1 and no completion occurs that cycle, frame_ready←0.
  - When frame_ready=0, it is ignored.
  - Simultaneous ack and completion: the ack is honoured first, then the swap happens. frame_ready stays 1 and frame_count increments.
- Reads:
  - rd_data ← rd_bank[rd_addr] when rd_addr < M_eff, otherwise 0.
  - Reads are allowed regardless of frame_ready and state. A swap in the same cycle as rd_en returns data from the pre-swap rd_bank.
- Changing ptos_x_ciclo mid-frame is unsupported. Software toggles enable after changing it.

## Timing
- Reset values: rd_data=0, rd_data_valid=0, frame_ready=0, frame_count=0, frames_dropped=0. Internally wr_bank=0, rd_bank=1, wr_idx=0, state IDLE.
- Bank contents are not cleared by reset.
- Reset mid-frame: the partial frame is lost, and the next frame starts at point 0 once enable is high.
- Write latency: a sample valid at cycle t is written at the edge ending cycle t+1.
- frame_ready rises 2 cycles after the valid carrying point M_eff−1.
- frame_ack at cycle t clears frame_ready at t+1.
- Read latency: 1 cycle. rd_en at t gives rd_data and rd_data_valid=1 at t+1. Back-to-back reads give one word per cycle.
- Throughput: one sample per clock, with no backpressure upstream.

## Test plan
- Single frame: M=8, shift_norm=2, data_in 4,8,…,32 → frame_ready=1 two cycles after the 8th valid. Reading addresses 0..7 returns 1..8 with 1-cycle latency, and frame_count=1.
- Signed shift: M=4, shift_norm=3, inputs −8, −9, 7, 0x7FFFFFF8 → −1, −2, 0, 0x0FFFFFFF.
- Drop: M=4, send 3 frames with no ack → frame_ready=1, frame_count=1, frames_dropped=2. The read data is frame 1. After ack, the next frame is delivered and frame_count=2.
- Simultaneous ack and completion: assert frame_ack in the cycle the 2nd frame completes → frame_ready stays 1, frame_count=2, frames_dropped=0, and the read returns frame 2.
- Enable low mid-frame: M=8, 5 valids, then enable=0 for 3 cycles, then 8 valids → the first 5 are discarded, the frame holds the last 8, and the prior frame stays readable while enable is low.
- Boundaries: ptos_x_ciclo=0 → no frame_ready, no writes. ptos_x_ciclo=3000 → the frame completes after 2048 valids. rd_addr ≥ M_eff → rd_data=0 with rd_data_valid=1.
